sc_mul_rr_scheduler: RTL

- Time-shares one 16-bit stochastic-computing multiplier (Sobol-bit operands in, 6-bit popcount result out) among NUM_REQ requesters.
- Requesters use valid/ready handshakes; a round-robin arbiter grants one at a time.
- The block drives the multiplier operands, waits MUL_LATENCY cycles for the result to settle, then returns the result tagged with the requester ID.
- It sits between SC-CGRA PE operand buses and the shared SC multiplier instance.

---
 rtl/sc_sched_pkg.sv | 23 ++
 rtl/sc_mul_rr_scheduler_arbiter.sv | 31 +++
 rtl/sc_mul_rr_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sc_sched_pkg.sv
// Shared definitions for the stochastic-computing multiplier scheduler:
// FSM state encoding, default operand/result widths and a clog2 helper.
package sc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } sched_state_e;

  localparam int OPERAND_W_DEF = 6;
  localparam int RESULT_W_DEF  = 6;

  function automatic int sc_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_mul_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping around, as a one-hot vector plus its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] pick;

  // Prefer requesters at or above the pointer; fall back to the lowest one.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i >= int'(ptr_i));
    end
    pick  = (|(req_i & hi_mask)) ? (req_i & hi_mask) : req_i;
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) idx_o = ID_W'(i);
    end
    gnt_o = '0;
    if (|pick) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/sc_mul_rr_scheduler.sv
// Time-shares one SC multiplier among NUM_REQ requesters with round-robin
// grants. Optional statistics counters are enabled by SC_MUL_SCHED_STATS_EN.
module sc_mul_rr_scheduler
  import sc_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int OPERAND_W   = OPERAND_W_DEF,
  parameter int RESULT_W    = RESULT_W_DEF,
  parameter int MUL_LATENCY = 1,
  parameter int ID_W        = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_a,
  input  logic [NUM_REQ*OPERAND_W-1:0]   req_b,
  output logic [OPERAND_W-1:0]           mul_a,
  output logic [OPERAND_W-1:0]           mul_b,
  input  logic [RESULT_W-1:0]            mul_result,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [RESULT_W-1:0]            rsp_result,
  output logic [ID_W-1:0]                rsp_id,
  output logic                           busy
`ifdef SC_MUL_SCHED_STATS_EN
  ,
  output logic [15:0]                    op_count,
  output logic [15:0]                    stall_count
`endif
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? sc_clog2(MUL_LATENCY) : 1;

  sched_state_e          state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       id_q;
  logic [OPERAND_W-1:0]  mul_a_q;
  logic [OPERAND_W-1:0]  mul_b_q;
  logic                  rsp_valid_q;
  logic [RESULT_W-1:0]   rsp_result_q;
  logic [ID_W-1:0]       rsp_id_q;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       ptr_d;
  logic [OPERAND_W-1:0]  a_arr [NUM_REQ];
  logic [OPERAND_W-1:0]  b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*OPERAND_W +: OPERAND_W];
    assign b_arr[g] = req_b[g*OPERAND_W +: OPERAND_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign req_ready  = (state_q == ST_IDLE) ? gnt : '0;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      id_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            mul_a_q <= a_arr[gnt_idx];
            mul_b_q <= b_arr[gnt_idx];
            id_q    <= gnt_idx;
            ptr_q   <= ptr_d;
            cnt_q   <= CNT_W'(MUL_LATENCY - 1);
            state_q <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (cnt_q == '0) begin
            rsp_result_q <= mul_result;
            rsp_id_q     <= id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          // Response drains before any new grant; IDLE arbitrates next cycle.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SC_MUL_SCHED_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    op_count_d    = op_count_q;
    stall_count_d = stall_count_q;
    if (state_q == ST_RESP) begin
      if (rsp_ready) op_count_d = op_count_q + 16'd1;
      else if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      op_count_q    <= op_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
